// File: rtl/reg_shadow_writer.sv
// reg_shadow_writer
//   Register-bus initiator that commits one shadowed-register value per client
//   command: a phase-clearing read, two identical writes and (optionally) a
//   readback compare. Reports a single completion record per command.
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o          client command handshake (ready only in IDLE)
//   cmd_addr_i, cmd_wdata_i          shadowed register address and value
//   rsp_valid_o/rsp_ready_i          completion handshake, rsp_* held until accepted
//   rsp_status_o                     0 OK, 1 BUS_ERR, 2 MISMATCH, 3 TIMEOUT
//   rsp_stage_o                      beat that ended the sequence: 0 CLR, 1 WR0, 2 WR1, 3 VRFY
//   rsp_rdata_o                      readback data of a completed VRFY beat, else 0
//   reg_addr_o/write/wdata/wstrb     registered reg bus request fields
//   reg_valid_o/reg_ready_i          reg bus beat handshake
//   reg_rdata_i, reg_error_i         reg bus response, sampled on valid & ready
//
// States
//   IDLE | waiting for a command
//   CLR  | read of the target, resets the shadow slice phase
//   WR0  | first write of the value
//   WR1  | second write of the value (commits)
//   VRFY | readback of the committed value (Verify=1 only)
//   RESP | completion record presented to the client

module reg_shadow_writer #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter bit          Verify     = 1'b1,
  parameter int unsigned TimeoutCyc = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [1:0]      rsp_status_o,
  output logic [1:0]      rsp_stage_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic [AW-1:0]   reg_addr_o,
  output logic            reg_write_o,
  output logic [DW-1:0]   reg_wdata_o,
  output logic [DW/8-1:0] reg_wstrb_o,
  output logic            reg_valid_o,
  input  logic [DW-1:0]   reg_rdata_i,
  input  logic            reg_error_i,
  input  logic            reg_ready_i
);

  localparam int unsigned CW = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TimeoutCyc == 0) ? '0 : CW'(TimeoutCyc - 1);

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_BUS_ERR  = 2'd1;
  localparam logic [1:0] ST_MISMATCH = 2'd2;
  localparam logic [1:0] ST_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_WR0, S_WR1, S_VRFY, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            rsp_valid_d;
  logic [1:0]      status_d, stage_d;
  logic [DW-1:0]   rdata_d;
  logic            reg_valid_d, reg_write_d;
  logic [DW/8-1:0] reg_wstrb_d;
  logic            beat_done, tmo_hit;
  logic [1:0]      cur_stage;

  // Address and data come straight from the captured command; they only
  // matter while reg_valid_o is high, and the flops keep them stable.
  assign cmd_ready_o = (state_q == S_IDLE);
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;

  assign beat_done = reg_valid_o & reg_ready_i;
  assign tmo_hit   = (TimeoutCyc != 0) && reg_valid_o && !reg_ready_i && (tmo_q == TMO_LAST);

  always_comb begin
    cur_stage = 2'd0;
    case (state_q)
      S_WR0:   cur_stage = 2'd1;
      S_WR1:   cur_stage = 2'd2;
      S_VRFY:  cur_stage = 2'd3;
      default: cur_stage = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_o;
    status_d    = rsp_status_o;
    stage_d     = rsp_stage_o;
    rdata_d     = rsp_rdata_o;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (cmd_valid_i) state_d = S_CLR;
      end
      S_CLR, S_WR0, S_WR1, S_VRFY: begin
        if (beat_done) begin
          tmo_d = '0;
          if (reg_error_i) begin
            // Abort: the slice may be left at phase 1, the next CLR read fixes it.
            state_d  = S_RESP;
            status_d = ST_BUS_ERR;
            stage_d  = cur_stage;
          end else begin
            case (state_q)
              S_CLR: state_d = S_WR0;
              S_WR0: state_d = S_WR1;
              S_WR1: begin
                if (Verify) begin
                  state_d = S_VRFY;
                end else begin
                  state_d  = S_RESP;
                  status_d = ST_OK;
                  stage_d  = 2'd2;
                end
              end
              default: begin
                state_d  = S_RESP;
                stage_d  = 2'd3;
                rdata_d  = reg_rdata_i;
                status_d = (reg_rdata_i == wdata_q) ? ST_OK : ST_MISMATCH;
              end
            endcase
          end
        end else if (tmo_hit) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
          stage_d  = cur_stage;
          tmo_d    = '0;
        end else if (reg_valid_o) begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          status_d    = ST_OK;
          stage_d     = 2'd0;
          rdata_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_RESP && state_d == S_RESP) rsp_valid_d = 1'b1;

    // Bus request fields are registered from the state being entered.
    reg_valid_d = (state_d == S_CLR) || (state_d == S_WR0) ||
                  (state_d == S_WR1) || (state_d == S_VRFY);
    reg_write_d = (state_d == S_WR0) || (state_d == S_WR1);
    reg_wstrb_d = reg_write_d ? '1 : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      tmo_q        <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_status_o <= 2'd0;
      rsp_stage_o  <= 2'd0;
      rsp_rdata_o  <= '0;
      reg_valid_o  <= 1'b0;
      reg_write_o  <= 1'b0;
      reg_wstrb_o  <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_status_o <= status_d;
      rsp_stage_o  <= stage_d;
      rsp_rdata_o  <= rdata_d;
      reg_valid_o  <= reg_valid_d;
      reg_write_o  <= reg_write_d;
      reg_wstrb_o  <= reg_wstrb_d;
      if (state_q == S_IDLE && cmd_valid_i) begin
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_reg_shadow_writer.sv
// tb_reg_shadow_writer
//   Bench for reg_shadow_writer. Instance dut uses Verify=1 and a short
//   timeout; instance dut_nv uses Verify=0 against an always-ready slave.

module tb_reg_shadow_writer;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready;
  logic [31:0]   cmd_addr = '0, cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [1:0]    rsp_status, rsp_stage;
  logic [31:0]   rsp_rdata;
  logic [31:0]   reg_addr, reg_wdata;
  logic          reg_write, reg_valid;
  logic [3:0]    reg_wstrb;
  logic [31:0]   reg_rdata = '0;
  logic          reg_error = 1'b0, reg_ready = 1'b0;

  logic          b_cmd_valid = 1'b0, b_cmd_ready;
  logic [31:0]   b_cmd_addr = '0, b_cmd_wdata = '0;
  logic          b_rsp_valid, b_rsp_ready = 1'b0;
  logic [1:0]    b_rsp_status, b_rsp_stage;
  logic [31:0]   b_rsp_rdata;
  logic [31:0]   b_reg_addr, b_reg_wdata;
  logic          b_reg_write, b_reg_valid;
  logic [3:0]    b_reg_wstrb;
  logic [31:0]   b_reg_rdata = '0;
  logic          b_reg_error = 1'b0, b_reg_ready = 1'b1;

  reg_shadow_writer #(.AW(AW), .DW(DW), .Verify(1'b1), .TimeoutCyc(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_status_o(rsp_status), .rsp_stage_o(rsp_stage), .rsp_rdata_o(rsp_rdata),
    .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata),
    .reg_wstrb_o(reg_wstrb), .reg_valid_o(reg_valid),
    .reg_rdata_i(reg_rdata), .reg_error_i(reg_error), .reg_ready_i(reg_ready)
  );

  reg_shadow_writer #(.AW(AW), .DW(DW), .Verify(1'b0), .TimeoutCyc(TMO)) dut_nv (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready),
    .cmd_addr_i(b_cmd_addr), .cmd_wdata_i(b_cmd_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_status_o(b_rsp_status), .rsp_stage_o(b_rsp_stage), .rsp_rdata_o(b_rsp_rdata),
    .reg_addr_o(b_reg_addr), .reg_write_o(b_reg_write), .reg_wdata_o(b_reg_wdata),
    .reg_wstrb_o(b_reg_wstrb), .reg_valid_o(b_reg_valid),
    .reg_rdata_i(b_reg_rdata), .reg_error_i(b_reg_error), .reg_ready_i(b_reg_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One command: slave wait cycles per beat (>= TMO never answers), beat that
  // returns an error (-1 none), corrupted readback flag, rsp_ready delay.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    int          w0, w1, w2, w3;
    int          err_beat;
    bit          bad;
    int          rsp_delay;
    logic [1:0]  exp_status;
    logic [1:0]  exp_stage;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input int w0, input int w1, input int w2, input int w3,
                              input int err_beat, input bit bad, input int rsp_delay,
                              input logic [1:0] st, input logic [1:0] stg,
                              input logic [31:0] rd, input int cyc);
    vec_t v;
    v.addr = addr; v.wdata = wdata;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
    v.err_beat = err_beat; v.bad = bad; v.rsp_delay = rsp_delay;
    v.exp_status = st; v.exp_stage = stg; v.exp_rdata = rd; v.exp_cyc = cyc;
    return v;
  endfunction

  // Reference: walk the four beats, each costs wait+1 cycles or TMO cycles
  // if the slave stalls too long; the response appears the cycle after.
  function automatic void model(input vec_t v, output logic [1:0] st, output logic [1:0] stg,
                                output logic [31:0] rd, output int cyc, output int nb);
    int w[4];
    w = '{v.w0, v.w1, v.w2, v.w3};
    st = 2'd0; stg = 2'd3; rd = '0; cyc = 1; nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (w[i] >= TMO) begin
        cyc += TMO; st = 2'd3; stg = 2'(i);
        return;
      end
      cyc += w[i] + 1;
      nb = i + 1;
      if (v.err_beat == i) begin
        st = 2'd1; stg = 2'(i);
        return;
      end
    end
    rd = v.bad ? (v.wdata ^ 32'h1) : v.wdata;
    st = v.bad ? 2'd2 : 2'd0;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the
  // response handshake.
  task automatic run_cmd(input vec_t v);
    int waits[4];
    int c, beat_n, wait_cnt, delay, rsp_cyc, stab_err, hold_err, exp_nb, m_cyc;
    bit done, seen;
    logic [1:0]  got_st, got_stg, m_st, m_stg;
    logic [31:0] got_rd, m_rd;
    logic [68:0] snap;
    logic        obs_wr[4];
    logic [31:0] obs_addr[4], obs_wd[4];
    logic [3:0]  obs_ws[4];
    logic        exp_wr;

    waits = '{v.w0, v.w1, v.w2, v.w3};
    model(v, m_st, m_stg, m_rd, m_cyc, exp_nb);
    got_st = '0; got_stg = '0; got_rd = '0; snap = '0;
    for (int i = 0; i < 4; i++) begin
      obs_wr[i] = 1'b0; obs_addr[i] = '0; obs_wd[i] = '0; obs_ws[i] = '0;
    end

    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;

    c = 1; beat_n = 0; wait_cnt = 0; delay = v.rsp_delay;
    done = 1'b0; seen = 1'b0; stab_err = 0; hold_err = 0; rsp_cyc = -1;
    while (!done && c < 200) begin
      reg_ready = 1'b0; reg_error = 1'b0; reg_rdata = $urandom;
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1'b1; rsp_cyc = c;
          got_st = rsp_status; got_stg = rsp_stage; got_rd = rsp_rdata;
        end else if ({rsp_status, rsp_stage, rsp_rdata} != {got_st, got_stg, got_rd}) begin
          hold_err++;
        end
        if (cmd_ready || reg_valid) hold_err++;
        if (delay == 0) begin
          rsp_ready = 1'b1; done = 1'b1;
        end else begin
          delay--;
        end
      end else if (reg_valid) begin
        if (wait_cnt == 0) snap = {reg_write, reg_addr, reg_wdata, reg_wstrb};
        else if (snap != {reg_write, reg_addr, reg_wdata, reg_wstrb}) stab_err++;
        if (beat_n >= 4 || wait_cnt >= waits[beat_n]) begin
          reg_ready = 1'b1;
          if (beat_n < 4) begin
            reg_error = (beat_n == v.err_beat);
            if (beat_n == 3) reg_rdata = v.bad ? (v.wdata ^ 32'h1) : v.wdata;
            obs_wr[beat_n] = reg_write; obs_addr[beat_n] = reg_addr;
            obs_wd[beat_n] = reg_wdata; obs_ws[beat_n] = reg_wstrb;
          end
          beat_n++; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    rsp_ready = 1'b0; reg_ready = 1'b0; reg_error = 1'b0;

    check("rsp_seen", done, 1'b1);
    check("idle_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
    check("rsp_status", got_st, v.exp_status);
    check("rsp_stage", got_stg, v.exp_stage);
    check("rsp_rdata", got_rd, v.exp_rdata);
    check("rsp_cycle", rsp_cyc, v.exp_cyc);
    check("beat_count", beat_n, exp_nb);
    for (int i = 0; i < 4; i++) begin
      if (i < exp_nb && i < beat_n) begin
        exp_wr = (i == 1) || (i == 2);
        check($sformatf("beat%0d_fields", i),
              {obs_wr[i], obs_addr[i], obs_ws[i], exp_wr ? obs_wd[i] : 32'h0},
              {exp_wr, v.addr, exp_wr ? 4'hF : 4'h0, exp_wr ? v.wdata : 32'h0});
      end
    end
    check("req_stable", stab_err, 0);
    check("rsp_hold", hold_err, 0);
  endtask

  task automatic reset_mid_beat();
    int quiet;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reg_ready = 1'b1;
    @(posedge clk); #1;
    reg_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("wr0_pending", {reg_valid, reg_write, reg_addr}, {1'b1, 1'b1, 32'h30});
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_values",
          {cmd_ready, rsp_valid, rsp_status, rsp_stage, rsp_rdata,
           reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb},
          {1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0});
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", cmd_ready, 1'b1);
    quiet = 0;
    repeat (5) begin
      if (rsp_valid || reg_valid) quiet++;
      @(posedge clk); #1;
    end
    check("command_lost", quiet, 0);
  endtask

  task automatic verify_off_run();
    int c, nv;
    logic [7:0] mask;
    check("nv_cmd_ready", b_cmd_ready, 1'b1);
    b_cmd_valid = 1'b1; b_cmd_addr = 32'h40; b_cmd_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    c = 1; nv = 0; mask = '0;
    while (!b_rsp_valid && c < 20) begin
      if (b_reg_valid) begin
        if (nv < 8) mask[nv] = b_reg_write;
        nv++;
      end
      @(posedge clk); #1;
      c++;
    end
    check("nv_rsp_cycle", c, 4);
    check("nv_beats", nv, 3);
    check("nv_write_pattern", mask, 8'b0000_0110);
    check("nv_rsp", {b_rsp_status, b_rsp_stage, b_rsp_rdata}, {2'd0, 2'd2, 32'h0});
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
    check("nv_idle_after_rsp", {b_cmd_ready, b_rsp_valid}, 2'b10);
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    int r;
    logic [1:0]  m_st, m_stg;
    logic [31:0] m_rd;
    int m_cyc, m_nb;

    tbl[0] = mk(32'h10, 32'hA5A5_0F0F, 0, 0, 0, 0, -1, 1'b0, 0, 2'd0, 2'd3, 32'hA5A5_0F0F, 5);
    tbl[1] = mk(32'h14, 32'hA5A5_0F0F, 3, 3, 3, 3, -1, 1'b0, 1, 2'd0, 2'd3, 32'hA5A5_0F0F, 17);
    tbl[2] = mk(32'h18, 32'h0000_1111, 0, 0, 0, 0,  1, 1'b0, 0, 2'd1, 2'd1, 32'h0, 3);
    tbl[3] = mk(32'h18, 32'h2222_3333, 0, 0, 0, 0, -1, 1'b0, 2, 2'd0, 2'd3, 32'h2222_3333, 5);
    tbl[4] = mk(32'h10, 32'hA5A5_0F0F, 0, 0, 0, 0, -1, 1'b1, 0, 2'd2, 2'd3, 32'hA5A5_0F0E, 5);
    tbl[5] = mk(32'h1C, 32'hDEAD_BEEF, 0, 0, 99, 0, -1, 1'b0, 0, 2'd3, 2'd2, 32'h0, 11);
    tbl[6] = mk(32'h20, 32'h0BAD_F00D, 7, 0, 0, 0, -1, 1'b0, 0, 2'd0, 2'd3, 32'h0BAD_F00D, 12);
    tbl[7] = mk(32'h24, 32'h0000_0001, 0, 0, 0, 0,  0, 1'b0, 0, 2'd1, 2'd0, 32'h0, 2);
    tbl[8] = mk(32'h28, 32'hFFFF_FFFF, 1, 0, 2, 0,  3, 1'b0, 0, 2'd1, 2'd3, 32'h0, 8);
    tbl[9] = mk(32'h2C, 32'h0000_0005, 99, 0, 0, 0, -1, 1'b0, 0, 2'd3, 2'd0, 32'h0, 9);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_values",
          {cmd_ready, rsp_valid, rsp_status, rsp_stage, rsp_rdata,
           reg_valid, reg_write, reg_addr, reg_wdata, reg_wstrb},
          {1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0});
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

    reset_mid_beat();
    run_cmd(tbl[0]);

    for (int n = 0; n < 30; n++) begin
      v.addr = $urandom; v.wdata = $urandom;
      r = $urandom_range(0, 19); v.w0 = (r < 12) ? r % 4 : (r < 18) ? $urandom_range(4, 7) : (r == 18) ? 8 : 30;
      r = $urandom_range(0, 19); v.w1 = (r < 12) ? r % 4 : (r < 18) ? $urandom_range(4, 7) : (r == 18) ? 8 : 30;
      r = $urandom_range(0, 19); v.w2 = (r < 12) ? r % 4 : (r < 18) ? $urandom_range(4, 7) : (r == 18) ? 8 : 30;
      r = $urandom_range(0, 19); v.w3 = (r < 12) ? r % 4 : (r < 18) ? $urandom_range(4, 7) : (r == 18) ? 8 : 30;
      r = $urandom_range(0, 11); v.err_beat = (r < 4) ? r : -1;
      v.bad = ($urandom_range(0, 3) == 0);
      v.rsp_delay = $urandom_range(0, 3);
      model(v, m_st, m_stg, m_rd, m_cyc, m_nb);
      v.exp_status = m_st; v.exp_stage = m_stg; v.exp_rdata = m_rd; v.exp_cyc = m_cyc;
      run_cmd(v);
    end

    verify_off_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
